// File: rtl/tas_ram_arbiter_if.sv
// Bus between the averaging channels / temperature RAM and the RAM write arbiter.
// The requester side (channels and RAM) uses master; the arbiter uses slave.
interface tas_ram_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 11,
   parameter int unsigned DW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic               ram_wr_n;
   logic [AW-1:0]      ram_addr;
   logic [DW-1:0]      ram_data;
   logic               busy;
   logic               wrap;

   modport master (
      output req,
      output req_data,
      input  gnt,
      input  ram_wr_n,
      input  ram_addr,
      input  ram_data,
      input  busy,
      input  wrap
   );

   modport slave (
      input  req,
      input  req_data,
      output gnt,
      output ram_wr_n,
      output ram_addr,
      output ram_data,
      output busy,
      output wrap
   );
endinterface

// File: rtl/tas_ram_arbiter.sv
// Round-robin arbiter and timed write sequencer for the shared temperature RAM.
// One channel is granted per write; the RAM address counts down and wraps at zero.
module tas_ram_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned WR_CYC = 25,
   parameter int unsigned AW     = 11,
   parameter int unsigned DW     = 8
) (
   input logic             clk_50,
   input logic             reset,
   tas_ram_arbiter_if.slave bus
);

   localparam int unsigned RW = $clog2(NREQ);
   localparam int unsigned CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StRecover
   } state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   rr_last_q, rr_last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            wr_n_q, wr_n_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            busy_q, busy_d;
   logic            wrap_q, wrap_d;

   logic            win_valid;
   logic [RW-1:0]   win_idx;
   logic [RW-1:0]   scan_idx;

   // Scan starts just after the last winner, so it has the lowest priority next time.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         scan_idx = RW'((32'(rr_last_q) + off) % NREQ);
         if (!win_valid && bus.req[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      wr_n_d    = 1'b1;
      addr_d    = addr_q;
      data_d    = data_q;
      wrap_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d          = StSetup;
               gnt_d[win_idx]   = 1'b1;
               data_d           = bus.req_data[DW*win_idx +: DW];
               rr_last_d        = win_idx;
            end
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = '0;
            wr_n_d  = 1'b0;
         end
         StStrobe: begin
            if (cnt_q == CW'(WR_CYC - 1)) begin
               // Strobe ends and the next address appears on the same edge.
               state_d = StRecover;
               wrap_d  = (addr_q == '0);
               addr_d  = (addr_q == '0) ? '1 : addr_q - 1'b1;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               wr_n_d = 1'b0;
            end
         end
         StRecover: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q   <= StIdle;
         rr_last_q <= RW'(NREQ - 1);
         cnt_q     <= '0;
         gnt_q     <= '0;
         wr_n_q    <= 1'b1;
         addr_q    <= '1;
         data_q    <= '0;
         busy_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         wr_n_q    <= wr_n_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         wrap_q    <= wrap_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ram_wr_n = wr_n_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_data = data_q;
   assign bus.busy     = busy_q;
   assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_tas_ram_arbiter.sv
// Directed bench for tas_ram_arbiter: reset, single writes, round-robin order,
// address wrap over a full RAM sweep, and reset during a strobe.
module tb_tas_ram_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned WR_CYC = 25;
   localparam int unsigned AW     = 11;
   localparam int unsigned DW     = 8;

   logic clk_50 = 1'b0;
   logic reset  = 1'b1;

   int vectors     = 0;
   int miscompares = 0;
   int wrap_total  = 0;
   logic [AW-1:0] model_addr;

   always #5 clk_50 = ~clk_50;

   tas_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   tas_ram_arbiter #(
      .NREQ  (NREQ),
      .WR_CYC(WR_CYC),
      .AW    (AW),
      .DW    (DW)
   ) u_dut (
      .clk_50(clk_50),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      bus.req = '0;
      reset   = 1'b1;
      repeat (3) @(negedge clk_50);
      reset      = 1'b0;
      model_addr = '1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_wr_n"}, 32'(bus.ram_wr_n), 32'd1);
      check({tag, "_addr"}, 32'(bus.ram_addr), 32'h7FF);
      check({tag, "_data"}, 32'(bus.ram_data), 32'h00);
      check({tag, "_gnt"},  32'(bus.gnt),      32'h0);
      check({tag, "_busy"}, 32'(bus.busy),     32'd0);
      check({tag, "_wrap"}, 32'(bus.wrap),     32'd0);
   endtask

   // mode 0: drop granted req; 1: drop and re-raise one cycle later; 2: drop all reqs.
   // Returns at the falling edge of the first cycle back in IDLE.
   task automatic do_write(input logic [NREQ-1:0] exp_gnt, input logic [DW-1:0] exp_data,
                           input int mode);
      int waited    = 0;
      int k         = 0;
      int low       = 0;
      int first_low = -1;
      int busy_n    = 1;
      int wraps     = 0;
      logic held_ok = 1'b1;
      logic [NREQ-1:0] g;
      do begin
         @(negedge clk_50);
         waited++;
      end while (bus.gnt == '0 && waited < 60);
      g = bus.gnt;
      check("gnt", 32'(g), 32'(exp_gnt));
      check("gnt_latency", waited, 1);
      check("data_at_gnt", 32'(bus.ram_data), 32'(exp_data));
      check("addr_at_gnt", 32'(bus.ram_addr), 32'(model_addr));
      check("wr_n_setup", 32'(bus.ram_wr_n), 32'd1);
      if (mode == 2) bus.req = '0;
      else           bus.req = bus.req & ~g;
      while (bus.busy === 1'b1 && k < 60) begin
         @(negedge clk_50);
         k++;
         if (mode == 1 && k == 1) bus.req = bus.req | g;
         if (bus.ram_wr_n === 1'b0) begin
            if (first_low < 0) first_low = k;
            low++;
            if (bus.ram_addr !== model_addr || bus.ram_data !== exp_data) held_ok = 1'b0;
         end
         if (bus.wrap === 1'b1) begin
            wraps++;
            check("addr_on_wrap", 32'(bus.ram_addr), 32'h7FF);
         end
         if (bus.gnt !== '0) held_ok = 1'b0;
         if (bus.busy === 1'b1) busy_n++;
      end
      check("strobe_len", low, WR_CYC);
      check("strobe_start", first_low, 1);
      check("busy_len", busy_n, WR_CYC + 2);
      check("strobe_hold", 32'(held_ok), 32'd1);
      check("wrap_pulses", wraps, (model_addr == '0) ? 1 : 0);
      model_addr = model_addr - 1'b1;
      check("addr_after", 32'(bus.ram_addr), 32'(model_addr));
      wrap_total += wraps;
   endtask

   initial begin
      int low;
      int guard;

      bus.req      = '0;
      bus.req_data = '0;
      model_addr   = '1;

      // 1: reset state, and it holds while nothing requests
      do_reset();
      @(negedge clk_50);
      check_idle("rst");
      repeat (5) @(negedge clk_50);
      check_idle("rst_hold");

      // 2: single write from channel 0
      bus.req_data[7:0] = 8'h1A;
      bus.req           = 4'b0001;
      do_write(4'b0001, 8'h1A, 0);

      // 3: all channels held, round-robin from channel 0
      do_reset();
      bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      bus.req      = 4'b1111;
      do_write(4'b0001, 8'hA0, 1);
      do_write(4'b0010, 8'hB1, 1);
      do_write(4'b0100, 8'hC2, 1);
      do_write(4'b1000, 8'hD3, 1);
      do_write(4'b0001, 8'hA0, 2);

      // 4: rr_last=2, then 2 and 3 together -> 3 first
      do_reset();
      bus.req = 4'b0100;
      do_write(4'b0100, 8'hC2, 0);
      bus.req = 4'b1100;
      do_write(4'b1000, 8'hD3, 0);
      do_write(4'b0100, 8'hC2, 0);
      check("req_cleared_idle", 32'(bus.busy), 32'd0);

      // 5: full sweep of the RAM plus one, exactly one wrap
      do_reset();
      wrap_total = 0;
      bus.req    = 4'b0001;
      for (int k = 0; k <= 2048; k++) begin
         bus.req_data[7:0] = 8'(k);
         do_write(4'b0001, 8'(k), (k == 2048) ? 2 : 1);
      end
      check("sweep_wraps", wrap_total, 1);

      // 6: reset during the 10th strobe cycle of the write at 0x7FD
      do_reset();
      bus.req_data[7:0] = 8'h11;
      bus.req           = 4'b0001;
      do_write(4'b0001, 8'h11, 0);
      bus.req_data[7:0] = 8'h22;
      bus.req           = 4'b0001;
      do_write(4'b0001, 8'h22, 0);
      bus.req_data[7:0] = 8'h66;
      bus.req           = 4'b0001;
      guard = 0;
      do begin
         @(negedge clk_50);
         guard++;
      end while (bus.gnt == '0 && guard < 60);
      check("abort_gnt", 32'(bus.gnt), 32'b0001);
      bus.req = '0;
      low     = 0;
      guard   = 0;
      while (low < 10 && guard < 60) begin
         @(negedge clk_50);
         guard++;
         if (bus.ram_wr_n === 1'b0) low++;
      end
      check("abort_strobe_addr", 32'(bus.ram_addr), 32'h7FD);
      check("abort_strobe_low", 32'(bus.ram_wr_n), 32'd0);
      reset = 1'b1;
      @(negedge clk_50);
      check_idle("abort");
      reset = 1'b0;
      repeat (30) @(negedge clk_50);
      check_idle("post_abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
